nibble_serial_sub: RTL and testbench
====================================

# nibble_serial_sub

Sequential multi-nibble subtractor for the clocked carry-chain datapath. It computes D = A − B − bi over WIDTH bits, one 4-bit slice per clock, through a single 4-bit subtract slice and a registered borrow/carry. It is the inverse-operation companion to the combinational 4-bit adder stages. It trades area for latency when wide operands arrive only occasionally.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 4; N = WIDTH/4 slices
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when not busy
- a  in  WIDTH  minuend; captured on accepted start
- b  in  WIDTH  subtrahend; captured on accepted start
- bi  in  1  borrow-in; captured on accepted start
- busy  out  1  high while slices are being processed
- done  out  1  one-cycle pulse; d/bo/ovf valid from this cycle on
- d  out  WIDTH  difference a − b − bi, modulo 2^WIDTH
- bo  out  1  unsigned borrow-out: 1 when a < b + bi
- ovf  out  1  signed two's-complement overflow

## Operation
- States:
  - IDLE: no operation in progress.
  - RUN: slices being processed.
  - DONE: one-cycle result-reporting state.
- IDLE or DONE with start=1:
  - Capture a, b, bi.
  - Load the carry register with ~bi.
  - Clear slice index k to 0.
  - Go to RUN.
- RUN, each cycle:
  - {c, s} = a[4k+3:4k] + ~b[4k+3:4k] + c.
  - Write s into d[4k+3:4k] and register c.
  - k increments; after slice N−1, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - bo = ~c_final.
  - ovf = (a[W−1] ^ b[W−1]) & (a[W−1] ^ d[W−1]), using the captured operands.
  - Next state: IDLE, or RUN if start=1 (back-to-back).
- start while busy is ignored. It is not queued, and captured operands do not change.
- a, b and bi are don't-care outside the start cycle.
- d, bo and ovf hold their last result until the next accepted start.
  - d slices are overwritten progressively during RUN.
  - bo and ovf update only on entry to DONE.
- Reset values: state IDLE, busy=0, done=0, d=0, bo=0, ovf=0, k=0, c=0.
- rst asserted in any state, including mid-RUN, aborts the operation and restores the reset values on the next edge. No done is produced for the aborted operation.
- WIDTH=4 (N=1): RUN lasts one cycle; the k counter width is max(1, clog2(N)).

## Timing
- start high in cycle 0 → busy high in cycles 1..N → done high in cycle N+1.
- Latency from start to done is N+1 cycles; 5 cycles for WIDTH=16.
- Throughput: one operation per N+1 cycles when start is held high.
  - start seen in the DONE cycle is accepted; busy rises the next cycle.
- busy = (state == RUN); done = (state == DONE); both come straight from registers, with no combinational path from inputs.
- Critical path is one 4-bit slice plus a mux; it is independent of WIDTH.

## Structure
- Shared package holds:
  - the state encoding (IDLE, RUN, DONE);
  - the SLICE_W = 4 constant;
  - a function giving the index width from WIDTH.
- One sub-module, sub4_slice:
  - inputs a[3:0], b[3:0], ci; outputs s[3:0], co;
  - computes a + ~b + ci;
  - purely combinational, instantiated once.
- Top level holds the FSM, the k counter, the operand registers, the carry register, the result registers and the ovf logic.

## Test plan
All cases use WIDTH=16.
- a=0x1234, b=0x0234, bi=0 → done in cycle 5; d=0x1000, bo=0, ovf=0; busy high in exactly cycles 1–4.
- a=0x0000, b=0x0001, bi=0 → d=0xFFFF, bo=1, ovf=0.
- a=0x8000, b=0x0001, bi=0 → d=0x7FFF, bo=0, ovf=1. Then a=0x7FFF, b=0xFFFF → d=0x8000, bo=1, ovf=1.
- a=0x0005, b=0x0003, bi=1 → d=0x0001, bo=0. Then a=0x0000, b=0x0000, bi=1 → d=0xFFFF, bo=1.
- start held high with new operands on every cycle:
  - the first operation completes with its original result;
  - starts during cycles 1–4 are ignored;
  - the operands present in cycle 5 (the DONE cycle) are accepted, and their done appears in cycle 10.
- rst pulsed in cycle 2 of an operation → next cycle busy=0, done=0, d=0, bo=0, ovf=0; no done follows. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/nibble_serial_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM encoding, slice width
// and the slice-index width helper.
package nibble_serial_sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index counter never narrower than one bit, even for a single slice.
  function automatic int idx_width(input int width);
    int n;
    n = width / SLICE_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_sub_if.sv
// Request/result bundle of the nibble-serial subtractor; the requester uses the
// master modport, the subtractor the slave modport.
interface nibble_serial_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;

  modport master (
    output start, a, b, bi,
    input  busy, done, d, bo, ovf
  );

  modport slave (
    input  start, a, b, bi,
    output busy, done, d, bo, ovf
  );
endinterface

// File: rtl/nibble_serial_sub_sub4_slice.sv
// Combinational 4-bit subtract slice: a + ~b + ci, where ci is the inverted
// borrow coming from the slice below.
module sub4_slice
  import nibble_serial_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, ci};
  assign s   = sum[SLICE_W-1:0];
  assign co  = sum[SLICE_W];

endmodule

// File: rtl/nibble_serial_sub.sv
// Sequential WIDTH-bit subtractor D = A - B - bi, one nibble per clock through a
// single shared sub4_slice with a registered carry.
module nibble_serial_sub
  import nibble_serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  nibble_serial_sub_if.slave  bus
);

  localparam int             N      = WIDTH / SLICE_W;
  localparam int             K_W    = idx_width(WIDTH);
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  state_t state_reg, state_next;
  logic   load, step;

  logic [WIDTH-1:0] a_reg, b_reg, d_reg;
  logic [K_W-1:0]   k_reg;
  logic             c_reg, bo_reg, ovf_reg;

  logic [SLICE_W-1:0] a_sl [N];
  logic [SLICE_W-1:0] b_sl [N];
  logic [SLICE_W-1:0] a_cur, b_cur, s;
  logic               co;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slices
      assign a_sl[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_sl[gi] = b_reg[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  assign a_cur = a_sl[k_reg];
  assign b_cur = b_sl[k_reg];

  sub4_slice u_slice (
    .a  (a_cur),
    .b  (b_cur),
    .ci (c_reg),
    .s  (s),
    .co (co)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (k_reg == K_LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        // A start in the reporting cycle launches the next operation directly.
        if (bus.start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      d_reg   <= '0;
      k_reg   <= '0;
      c_reg   <= 1'b0;
      bo_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      if (load) begin
        a_reg <= bus.a;
        b_reg <= bus.b;
        c_reg <= ~bus.bi;
        k_reg <= '0;
      end
      if (step) begin
        for (int i = 0; i < N; i++) begin
          if (k_reg == K_W'(i)) d_reg[i*SLICE_W +: SLICE_W] <= s;
        end
        c_reg <= co;
        k_reg <= (k_reg == K_LAST) ? '0 : k_reg + 1'b1;
        // The top slice carries the sign bit, so flags resolve on the last step.
        if (k_reg == K_LAST) begin
          bo_reg  <= ~co;
          ovf_reg <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (a_reg[WIDTH-1] ^ s[SLICE_W-1]);
        end
      end
    end
  end

  assign bus.busy = (state_reg == ST_RUN);
  assign bus.done = (state_reg == ST_DONE);
  assign bus.d    = d_reg;
  assign bus.bo   = bo_reg;
  assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub (WIDTH=16): directed table, random
// operands against an arithmetic reference, back-to-back and reset-abort sequences.
module tb_nibble_serial_sub;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  nibble_serial_sub_if #(.WIDTH(W)) bus_if ();

  nibble_serial_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                                  output logic [W-1:0] d, output logic bo, output logic ovf);
    int ua, ub, diff, sa, sb, sd;
    ua   = int'(a);
    ub   = int'(b);
    diff = ua - ub - int'(bi);
    d    = diff[W-1:0];
    bo   = (diff < 0);
    sa   = $signed(a);
    sb   = $signed(b);
    sd   = sa - sb - int'(bi);
    ovf  = (sd > 32767) || (sd < -32768);
  endfunction

  // Issues one start (cycle 0) and waits for done; lat is the done cycle number.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        output logic [W-1:0] d, output logic bo, output logic ovf,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.bi    = bi;
    busy_ok      = 1'b1;
    @(negedge clk);
    lat          = 1;
    bus_if.start = 1'b0;
    bus_if.a     = W'($urandom);
    bus_if.b     = W'($urandom);
    bus_if.bi    = 1'($urandom);
    while (!bus_if.done && lat < 20) begin
      if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus_if.busy !== 1'b0) busy_ok = 1'b0;
    d   = bus_if.d;
    bo  = bus_if.bo;
    ovf = bus_if.ovf;
  endtask

  initial begin
    logic [W-1:0] gd, ed;
    logic         gbo, gov, ebo, eov;
    int           lat, seen;
    bit           bok;
    logic [W-1:0] seq_a [12];
    logic [W-1:0] seq_b [12];
    logic         seq_bi [12];

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.bi    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    check("reset_done", 32'(bus_if.done), 32'd0);
    check("reset_d",    32'(bus_if.d),    32'd0);
    check("reset_bo",   32'(bus_if.bo),   32'd0);
    check("reset_ovf",  32'(bus_if.ovf),  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, gd, gbo, gov, lat, bok);
      $display("vec%0d a=%h b=%h bi=%0d -> d=%h bo=%0d ovf=%0d done@%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].bi, gd, gbo, gov, lat);
      check($sformatf("vec%0d_d", i),    32'(gd),  32'(vecs[i].d));
      check($sformatf("vec%0d_bo", i),   32'(gbo), 32'(vecs[i].bo));
      check($sformatf("vec%0d_ovf", i),  32'(gov), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_lat", i),  32'(lat), 32'd5);
      check($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
    end

    // Result must hold after done while idle.
    @(negedge clk);
    @(negedge clk);
    check("hold_d",    32'(bus_if.d),    32'(vecs[5].d));
    check("hold_bo",   32'(bus_if.bo),   32'(vecs[5].bo));
    check("hold_done", 32'(bus_if.done), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbi;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      if (i == 0) begin ra = 16'hFFFF; rb = 16'h0000; rbi = 1'b0; end
      if (i == 1) begin ra = 16'h8000; rb = 16'h7FFF; rbi = 1'b1; end
      run_op(ra, rb, rbi, gd, gbo, gov, lat, bok);
      ref_sub(ra, rb, rbi, ed, ebo, eov);
      $display("rnd%0d a=%h b=%h bi=%0d -> d=%h bo=%0d ovf=%0d", i, ra, rb, rbi, gd, gbo, gov);
      check($sformatf("rnd%0d_d", i),   32'(gd),  32'(ed));
      check($sformatf("rnd%0d_bo", i),  32'(gbo), 32'(ebo));
      check($sformatf("rnd%0d_ovf", i), 32'(gov), 32'(eov));
    end

    // Back-to-back: start held high with fresh operands every cycle.
    @(negedge clk);
    seen = 0;
    for (int c = 0; c <= 11; c++) begin
      if (c >= 1) begin
        if (c == 5 || c == 10) begin
          ref_sub(seq_a[c-5], seq_b[c-5], seq_bi[c-5], ed, ebo, eov);
          $display("b2b cycle %0d done=%0d d=%h bo=%0d ovf=%0d", c, bus_if.done, bus_if.d, bus_if.bo, bus_if.ovf);
          check($sformatf("b2b_done_c%0d", c), 32'(bus_if.done), 32'd1);
          check($sformatf("b2b_d_c%0d", c),    32'(bus_if.d),    32'(ed));
          check($sformatf("b2b_bo_c%0d", c),   32'(bus_if.bo),   32'(ebo));
          check($sformatf("b2b_ovf_c%0d", c),  32'(bus_if.ovf),  32'(eov));
        end else if (bus_if.done) begin
          seen++;
        end
      end
      if (c <= 9) begin
        seq_a[c]     = W'($urandom);
        seq_b[c]     = W'($urandom);
        seq_bi[c]    = 1'($urandom);
        bus_if.start = 1'b1;
        bus_if.a     = seq_a[c];
        bus_if.b     = seq_b[c];
        bus_if.bi    = seq_bi[c];
      end else begin
        bus_if.start = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_stray_done", 32'(seen), 32'd0);

    // Reset pulsed in cycle 2 of an operation aborts it.
    bus_if.start = 1'b1;
    bus_if.a     = 16'hABCD;
    bus_if.b     = 16'h1111;
    bus_if.bi    = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("abort busy=%0d done=%0d d=%h bo=%0d ovf=%0d", bus_if.busy, bus_if.done, bus_if.d, bus_if.bo, bus_if.ovf);
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_done", 32'(bus_if.done), 32'd0);
    check("abort_d",    32'(bus_if.d),    32'd0);
    check("abort_bo",   32'(bus_if.bo),   32'd0);
    check("abort_ovf",  32'(bus_if.ovf),  32'd0);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_if.done || bus_if.busy) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    run_op(vecs[0].a, vecs[0].b, vecs[0].bi, gd, gbo, gov, lat, bok);
    $display("post-abort a=%h b=%h -> d=%h bo=%0d ovf=%0d done@%0d", vecs[0].a, vecs[0].b, gd, gbo, gov, lat);
    check("post_abort_d",   32'(gd),  32'(vecs[0].d));
    check("post_abort_lat", 32'(lat), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
